// File: rtl/keypad_pkg.sv
// Shared key codes, entry FSM states and key classification for keypad operand entry.
// Optional backspace key support is enabled by defining KEYPAD_BACKSPACE_EN.
package keypad_pkg;

  localparam logic [3:0] KEY_CONFIRM = 4'hA;
  localparam logic [3:0] KEY_BACK    = 4'hB;
  localparam logic [3:0] KEY_CLEAR   = 4'hC;

  typedef enum logic [2:0] {
    ENTRY_A = 3'd0,
    CONV_A  = 3'd1,
    ENTRY_B = 3'd2,
    CONV_B  = 3'd3,
    DONE    = 3'd4
  } entry_state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one multiply-by-10 accumulate per cycle, MSD first.
// done_o marks the final cycle, when result_o already carries the finished value.
module bcd2bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = $clog2(10**DIGITS)
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start_i,
  input  logic [4*DIGITS-1:0]   digits_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [BIN_W-1:0]      result_o
);
  import keypad_pkg::*;

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [BIN_W-1:0] acc_q, acc_d, mac;
  logic [IW-1:0]    idx_q, idx_d;
  logic             run_q, run_d;
  logic [3:0]       digit;

  assign digit = digits_i[int'(idx_q)*4 +: 4];
  assign mac   = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);

  assign busy_o   = run_q;
  assign done_o   = run_q && (idx_q == '0);
  assign result_o = mac;

  // Next accumulator/index: clear on start, then walk digits downward.
  always_comb begin
    acc_d = acc_q;
    idx_d = idx_q;
    run_d = run_q;
    if (start_i) begin
      acc_d = '0;
      idx_d = IW'(DIGITS - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = mac;
      if (idx_q == '0) run_d = 1'b0;
      else             idx_d = idx_q - 1'b1;
    end
  end

  // Conversion state registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: collects two BCD operands, converts each to binary, hands off.
// Define KEYPAD_BACKSPACE_EN to make key B delete the last entered digit.
module keypad_operand_entry #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = $clog2(10**DIGITS)
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic [3:0]                   key_code,
  input  logic                         key_valid,
  input  logic                         ack,
  output logic [BIN_W-1:0]             operand_a,
  output logic [BIN_W-1:0]             operand_b,
  output logic                         operands_valid,
  output logic [4*DIGITS-1:0]          entry_bcd,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         entry_sel,
  output logic                         busy
);
  import keypad_pkg::*;

  localparam int CW = $clog2(DIGITS + 1);
  localparam int EW = 4 * DIGITS;

  entry_state_t   state_q, state_d;
  logic           key_v_q;
  logic [3:0]     key_q;
  logic [EW-1:0]  bcd_q, bcd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0] opa_q, opa_d, opb_q, opb_d;
  logic           conv_start, conv_busy, conv_done;
  logic [BIN_W-1:0] conv_res;
  logic           in_conv, in_entry;

  assign in_conv  = (state_q == CONV_A) || (state_q == CONV_B);
  assign in_entry = (state_q == ENTRY_A) || (state_q == ENTRY_B);

  bcd2bin_seq #(
    .DIGITS (DIGITS),
    .BIN_W  (BIN_W)
  ) u_conv (
    .clk      (clk),
    .n_reset  (n_reset),
    .start_i  (conv_start),
    .digits_i (bcd_q),
    .busy_o   (conv_busy),
    .done_o   (conv_done),
    .result_o (conv_res)
  );

  // Key capture; keys arriving mid-conversion or alongside an ack are dropped.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      key_v_q <= 1'b0;
      key_q   <= 4'h0;
    end else begin
      key_v_q <= key_valid && !in_conv && !((state_q == DONE) && ack);
      key_q   <= key_code;
    end
  end

  // Entry FSM next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    opa_d      = opa_q;
    opb_d      = opb_q;
    conv_start = 1'b0;
    unique case (state_q)
      ENTRY_A, ENTRY_B: begin
        if (key_v_q) begin
          unique case (1'b1)
            is_digit(key_q): begin
              if (cnt_q < CW'(DIGITS)) begin
                bcd_d = EW'({bcd_q, key_q});
                cnt_d = cnt_q + 1'b1;
              end
            end
            key_q == KEY_CONFIRM: begin
              conv_start = 1'b1;
              state_d = (state_q == ENTRY_A) ? CONV_A : CONV_B;
            end
            key_q == KEY_CLEAR: begin
              bcd_d   = '0;
              cnt_d   = '0;
              opa_d   = '0;
              opb_d   = '0;
              state_d = ENTRY_A;
            end
`ifdef KEYPAD_BACKSPACE_EN
            key_q == KEY_BACK: begin
              if (cnt_q != '0) begin
                bcd_d = bcd_q >> 4;
                cnt_d = cnt_q - 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end
      end
      CONV_A: begin
        if (conv_done) begin
          opa_d   = conv_res;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = ENTRY_B;
        end
      end
      CONV_B: begin
        if (conv_done) begin
          opb_d   = conv_res;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (ack) begin
          opa_d   = '0;
          opb_d   = '0;
          state_d = ENTRY_A;
        end else if (key_v_q && (key_q == KEY_CLEAR)) begin
          bcd_d   = '0;
          cnt_d   = '0;
          opa_d   = '0;
          opb_d   = '0;
          state_d = ENTRY_A;
        end
      end
      default: state_d = ENTRY_A;
    endcase
  end

  // State and operand registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ENTRY_A;
      bcd_q   <= '0;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
    end
  end

  assign operand_a      = opa_q;
  assign operand_b      = opb_q;
  assign operands_valid = (state_q == DONE);
  assign entry_bcd      = bcd_q;
  assign digit_count    = cnt_q;
  assign entry_sel      = (state_q == ENTRY_B) || (state_q == CONV_B) ||
                          (state_q == DONE);
  assign busy           = in_conv && conv_busy;

  logic unused_ok;
  assign unused_ok = in_entry;

endmodule
